// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the RV32I fetch stage.
//   state_e       : fetch controller FSM states
//   NOP_INSTR     : canonical RV32I NOP (addi x0, x0, 0), shown on an empty head
//   fetch_entry_t : one buffered fetch result {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      IDLE  = 2'd1,
      BUSY  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry FIFO of fetch entries. Entry 0 is always the head, so the head
// outputs come straight from flops with no read-pointer mux.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   push        : write push_entry this cycle
//   push_entry  : {pc, instr} to store
//   pop         : consume the head this cycle
//   flush       : empty the FIFO; wins over push and pop
//   head        : current head entry (meaningful when count != 0)
//   count       : registered occupancy, 0..2
// -----------------------------------------------------------------------------
module fetch_buf
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   localparam fetch_entry_t RESET_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

   fetch_entry_t ent0;
   fetch_entry_t ent1;
   logic [1:0]   cnt;
   logic         do_push;
   logic         do_pop;

   // Popping an empty FIFO is a no-op; a push into a full FIFO is only
   // accepted when a pop frees a slot in the same cycle.
   assign do_pop  = pop && (cnt != 2'd0);
   assign do_push = push && ((cnt != 2'd2) || do_pop);

   // NOTE: both storage slots are reset (not just the count) because entry 0
   // drives if_pc/if_instr directly and must show {0, NOP} out of reset.
   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge values; ent0 <= ent1 below relies on that.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent0 <= RESET_ENTRY;
         ent1 <= RESET_ENTRY;
         cnt  <= 2'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= push_entry;
               else             ent1 <= push_entry;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new entry lands behind the survivor.
               if (cnt == 2'd1) begin
                  ent0 <= push_entry;
               end else begin
                  ent0 <= ent1;
                  ent1 <= push_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = ent0;
   assign count = cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// RV32I fetch-stage PC sequencer and instruction-memory handshake controller.
// Owns the fetch PC, issues one outstanding word request at a time, buffers
// results in a 2-entry FIFO, and applies MEM-stage redirects (including those
// that arrive while a request is still in flight).
// Parameters:
//   RESET_PC        : first fetch address after reset (word aligned)
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   redirect_valid  : one-cycle redirect strobe from MEM
//   redirect_pc     : redirect target; bits [1:0] ignored
//   imem_req        : request to instruction memory (BUSY/DRAIN)
//   imem_addr       : word-aligned request address, stable until ack
//   imem_ack        : request done, imem_rdata valid this cycle
//   imem_rdata      : instruction word
//   if_valid        : head of the fetch buffer is valid
//   if_ready        : decode takes the head when if_valid & if_ready
//   if_pc, if_instr : head PC and instruction
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   state_e       state;
   state_e       state_nxt;
   logic [31:0]  pc;
   logic [31:0]  pc_nxt;
   logic [31:0]  hold_addr;
   logic [31:0]  hold_nxt;
   logic [31:0]  target;
   logic         push;
   logic         pop;
   logic [1:0]   count;
   logic [2:0]   occ_after;
   fetch_entry_t head;
   fetch_entry_t push_entry;

   assign target     = redirect_pc & ~32'h0000_0003;
   assign pop        = if_valid && if_ready;
   // Data returning in a redirect cycle belongs to the wrong path.
   assign push       = (state == BUSY) && imem_ack && !redirect_valid;
   assign push_entry = '{pc: pc, instr: imem_rdata};
   assign occ_after  = {1'b0, count} + {2'b00, push} - {2'b00, pop};

   // NOTE: every always_comb output gets a default first so no path leaves a
   // signal unassigned (which would infer a latch).
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      hold_nxt  = hold_addr;
      case (state)
         BOOT: begin
            state_nxt = BUSY;
            pc_nxt    = redirect_valid ? target : RESET_PC;
         end
         IDLE: begin
            if (redirect_valid) begin
               // The flush empties the buffer, so fetching can resume at once.
               pc_nxt    = target;
               state_nxt = BUSY;
            end else if (count <= 2'd1) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (redirect_valid) begin
               pc_nxt = target;
               if (!imem_ack) begin
                  // The old request must finish at its original address.
                  hold_nxt  = pc;
                  state_nxt = DRAIN;
               end
            end else if (imem_ack) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = (occ_after <= 3'd1) ? BUSY : IDLE;
            end
         end
         DRAIN: begin
            if (redirect_valid) pc_nxt = target;
            if (imem_ack)       state_nxt = BUSY;
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         hold_addr <= RESET_PC;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         hold_addr <= hold_nxt;
      end
   end

   // Request outputs depend only on registered state: no path from imem_ack
   // or if_ready reaches imem_req/imem_addr within a cycle.
   assign imem_req  = (state == BUSY) || (state == DRAIN);
   assign imem_addr = (state == DRAIN) ? hold_addr : pc;

   fetch_buf u_buf (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .head       (head),
      .count      (count)
   );

   assign if_valid = (count != 2'd0);
   assign if_pc    = head.pc;
   assign if_instr = head.instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. dut uses RESET_PC = 0 and a memory with a
// programmable number of wait states; dut_wrap uses RESET_PC = FFFF_FFF8 with
// a zero-wait memory and shares clk/rst. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   import fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_pc;
   logic [31:0] w_instr;

   int n_tests;
   int n_fail;
   int wait_states;
   int wait_cnt;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk), .rst (rst),
      .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
      .imem_req (imem_req), .imem_addr (imem_addr),
      .imem_ack (imem_ack), .imem_rdata (imem_rdata),
      .if_valid (if_valid), .if_ready (if_ready),
      .if_pc (if_pc), .if_instr (if_instr)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk (clk), .rst (rst),
      .redirect_valid (w_redirect_valid), .redirect_pc (w_redirect_pc),
      .imem_req (w_req), .imem_addr (w_addr),
      .imem_ack (w_ack), .imem_rdata (w_rdata),
      .if_valid (w_valid), .if_ready (w_ready),
      .if_pc (w_pc), .if_instr (w_instr)
   );

   // Memory models: ack after wait_states idle cycles of a held request.
   assign imem_ack   = imem_req && (wait_cnt == wait_states);
   assign imem_rdata = instr_of(imem_addr);
   assign w_ack      = w_req;
   assign w_rdata    = instr_of(w_addr);

   always @(posedge clk or negedge rst) begin
      if (!rst)                      wait_cnt <= 0;
      else if (!imem_req || imem_ack) wait_cnt <= 0;
      else                           wait_cnt <= wait_cnt + 1;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset(input int ws, input logic rdy);
      @(negedge clk);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      wait_states    = ws;
      if_ready       = rdy;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
      n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
      n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
      n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 00000000", if_pc); end
      n_tests++; if (if_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr: got %h want 00000013", if_instr); end
      n_tests++; if (w_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rst_wrap_addr: got %h want fffffff8", w_addr); end
      n_tests++; if (w_req !== 1'b0) begin n_fail++; $display("FAIL rst_wrap_req: got %b want 0", w_req); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] e;
      do_reset(0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         e = 32'(4 * k);
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== e) begin
            n_fail++; $display("FAIL zw_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, e);
         end
         if (k >= 1) begin
            e = 32'(4 * (k - 1));
            n_tests++;
            if (if_valid !== 1'b1 || if_pc !== e || if_instr !== instr_of(e)) begin
               n_fail++; $display("FAIL zw_head[%0d]: got v=%b pc=%h in=%h want v=1 pc=%h in=%h",
                                  k, if_valid, if_pc, if_instr, e, instr_of(e));
            end
         end
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] e;
      logic        ev;
      do_reset(3, 1'b1);
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk);
         e = 32'(4 * ((n - 1) / 4));
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== e) begin
            n_fail++; $display("FAIL ws_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", n, imem_req, imem_addr, e);
         end
         ev = (n >= 5) && (((n - 1) % 4) == 0);
         n_tests++;
         if (if_valid !== ev) begin
            n_fail++; $display("FAIL ws_valid[%0d]: got %b want %b", n, if_valid, ev);
         end
         if (ev) begin
            e = 32'(4 * ((n - 1) / 4 - 1));
            n_tests++;
            if (if_pc !== e) begin n_fail++; $display("FAIL ws_pc[%0d]: got %h want %h", n, if_pc, e); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(0, 1'b0);
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL bp_a0: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL bp_a4: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
      for (int n = 3; n <= 6; n++) begin
         @(negedge clk);
         n_tests++;
         if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_stall[%0d]: got req=%b v=%b pc=%h want req=0 v=1 pc=0", n, imem_req, if_valid, if_pc);
         end
      end
      if_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h4) begin n_fail++; $display("FAIL bp_drain4: got req=%b v=%b pc=%h want 0/1/4", imem_req, if_valid, if_pc); end
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin n_fail++; $display("FAIL bp_resume: got req=%b addr=%h v=%b want 1/8/0", imem_req, imem_addr, if_valid); end
      @(negedge clk);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL bp_pc8: got v=%b pc=%h addr=%h want 1/8/c", if_valid, if_pc, imem_addr); end
   endtask

   task automatic test_redirect_drain();
      do_reset(3, 1'b1);
      repeat (9) @(negedge clk);
      n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL rd_pre: got addr=%h want 8", imem_addr); end
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int n = 11; n <= 12; n++) begin
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_hold[%0d]: got req=%b addr=%h v=%b want 1/8/0", n, imem_req, imem_addr, if_valid);
         end
         @(negedge clk);
      end
      for (int n = 13; n <= 16; n++) begin
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_new[%0d]: got req=%b addr=%h v=%b want 1/100/0", n, imem_req, imem_addr, if_valid);
         end
         @(negedge clk);
      end
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== instr_of(32'h100)) begin
         n_fail++; $display("FAIL rd_head: got v=%b pc=%h in=%h want 1/100/%h", if_valid, if_pc, if_instr, instr_of(32'h100));
      end
   endtask

   task automatic test_redirect_ack();
      do_reset(0, 1'b1);
      repeat (3) @(negedge clk);
      n_tests++; if (imem_addr !== 32'h8 || imem_ack !== 1'b1) begin n_fail++; $display("FAIL ra_pre: got addr=%h ack=%b want 8/1", imem_addr, imem_ack); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin n_fail++; $display("FAIL ra_addr: got req=%b addr=%h v=%b want 1/200/0", imem_req, imem_addr, if_valid); end
      @(negedge clk);
      n_tests++; if (imem_addr !== 32'h204 || if_valid !== 1'b1 || if_pc !== 32'h200) begin n_fail++; $display("FAIL ra_head: got addr=%h v=%b pc=%h want 204/1/200", imem_addr, if_valid, if_pc); end
   endtask

   task automatic test_reset_mid();
      logic found;
      found = 1'b0;
      do_reset(3, 1'b1);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (imem_req === 1'b1 && imem_addr === 32'h40) begin
            found = 1'b1;
            break;
         end
      end
      n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rm_reach: got found=%b want 1 (addr 40 never requested)", found); end
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h3C) begin n_fail++; $display("FAIL rm_pre: got v=%b pc=%h want 1/3c", if_valid, if_pc); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_drop: got req=%b v=%b want 0/0", imem_req, if_valid); end
      n_tests++; if (imem_addr !== 32'h0 || if_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rm_vals: got addr=%h in=%h want 0/00000013", imem_addr, if_instr); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
      repeat (4) @(negedge clk);
      n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rm_head: got v=%b pc=%h want 1/0", if_valid, if_pc); end
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      do_reset(0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         e = 32'hFFFF_FFF8 + 32'(4 * k);
         n_tests++;
         if (w_req !== 1'b1 || w_addr !== e) begin
            n_fail++; $display("FAIL wrap_addr[%0d]: got req=%b addr=%h want 1/%h", k, w_req, w_addr, e);
         end
         if (k >= 1) begin
            e = e - 32'd4;
            n_tests++;
            if (w_valid !== 1'b1 || w_pc !== e || w_instr !== instr_of(e)) begin
               n_fail++; $display("FAIL wrap_head[%0d]: got v=%b pc=%h want 1/%h", k, w_valid, w_pc, e);
            end
         end
      end
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      rst              = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = 32'h0;
      if_ready         = 1'b1;
      wait_states      = 0;
      w_redirect_valid = 1'b0;
      w_redirect_pc    = 32'h0;
      w_ready          = 1'b1;

      test_reset();
      test_zero_wait();
      test_wait_states();
      test_backpressure();
      test_redirect_drain();
      test_redirect_ack();
      test_reset_mid();
      test_wrap();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

PC sequencer and instruction-memory handshake controller for the RV32I fetch stage. Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. Absorbs variable memory latency and decode back-pressure in a 2-entry {pc, instr} buffer. Applies branch/jump redirects from the MEM stage, including redirects that arrive while a request is still outstanding.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- redirect_valid  in  1  MEM-stage redirect strobe, one cycle per redirect.
- redirect_pc  in  32  redirect target, sampled when redirect_valid=1.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word-aligned request address; bits [1:0] always 0.
- imem_ack  in  1  request complete; imem_rdata valid in this cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  buffer head holds a valid instruction.
- if_ready  in  1  decode accepts the head; transfer occurs when if_valid & if_ready.
- if_pc  out  32  PC of the head instruction.
- if_instr  out  32  head instruction word.

## Operation

- FSM states: BOOT, IDLE, BUSY, DRAIN.
- imem_req = 1 only in BUSY and DRAIN.
- Once imem_req rises, it and imem_addr stay stable until the imem_ack cycle. This also holds across redirects.
- BOOT: first edge with rst high loads pc = RESET_PC and moves to BUSY.
- IDLE: no request outstanding. Moves to BUSY when the registered occupancy is ≤1.
- BUSY with ack and no redirect:
  - Push {pc, imem_rdata} into the buffer.
  - pc <= pc + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
  - Stay in BUSY if occupancy after this cycle's push and pop is ≤1; otherwise go to IDLE.
- BUSY without ack: stay in BUSY.
- Redirect in any state:
  - Flush the buffer: occupancy goes to 0 and if_valid is low from the next cycle.
  - pc <= {redirect_pc[31:2], 2'b00}. Bits [1:0] of redirect_pc are ignored.
  - A pop in the same cycle is still a completed transfer for decode, but the flush wins for buffer state.
- Redirect in BUSY with ack in the same cycle: discard imem_rdata and go to BUSY at the new pc.
- Redirect in BUSY without ack: go to DRAIN.
- DRAIN: keep the old request until ack, then discard the data and go to BUSY at the new pc. A further redirect in DRAIN replaces the pending pc and stays in DRAIN.
- Buffer: 2-entry FIFO, head presented on if_valid / if_pc / if_instr. Launching requests only at occupancy ≤1, with at most one outstanding, guarantees no overflow.
- Reset values (asynchronous, while rst=0):
  - state = BOOT, pc = RESET_PC, occupancy = 0.
  - imem_req = 0, imem_addr = RESET_PC.
  - if_valid = 0, if_pc = 0, if_instr = 32'h0000_0013 (NOP).
- Reset mid-request: the request is abandoned immediately. Memory must tolerate req dropping without ack.

## Timing

- imem_req rises on the first edge after rst deasserts (BOOT→BUSY).
- Zero-wait memory (ack in the same cycle as req) with if_ready held high gives one instruction per cycle.
- Fetch-to-decode latency: the ack edge pushes the entry, and if_valid is high in the following cycle.
- Redirect latency:
  - With no request outstanding, or ack in the same cycle, the new address appears on imem_addr in the cycle after redirect_valid.
  - Otherwise it appears in the cycle after the DRAIN ack.
- if_valid, if_pc and if_instr are registered. No combinational path from if_ready or imem_ack to imem_req or imem_addr.
- Push and pop in the same cycle at occupancy 1 leaves occupancy at 1. Push and pop at occupancy 2 cannot occur.

## Structure

- Package fetch_pkg:
  - state enum {BOOT, IDLE, BUSY, DRAIN}.
  - NOP_INSTR = 32'h0000_0013.
  - Fetch entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_buf: 2-entry FIFO of fetch entries with push, pop, flush and count. flush has priority over push and pop.
- The FSM, pc register and request logic live in fetch_ctrl.

## Test plan

- Reset, then zero-wait memory with if_ready=1 → imem_addr sequence 0, 4, 8, 12 on consecutive cycles; if_pc follows one cycle behind; if_valid never drops.
- Memory with 3 wait states → each address is held for 4 cycles with req stable; if_valid pulses once per fetch.
- if_ready=0 for 6 cycles → exactly 2 entries buffered and imem_req low (IDLE). Releasing if_ready drains PCs 0 then 4 and resumes at 8 without loss or duplication.
- Redirect to 32'h100 while a 3-wait-state request to 8 is outstanding → req to 8 held until ack and its data is never presented. The next request is to 0x100, and the first if_pc after the redirect is 0x100.
- Redirect with redirect_pc=32'h203 in the same cycle as an ack → ack data discarded; the next imem_addr is 32'h200.
- Assert rst low mid-request at pc=0x40 → imem_req and if_valid go to 0 immediately. After release, fetch restarts at RESET_PC. Also run with RESET_PC=32'hFFFF_FFF8 and check the address sequence FFFF_FFF8, FFFF_FFFC, 0.
